// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequences weight load, two-bank compute and flush for a
// ROWS x COLS weight-stationary PE grid. Every output is driven straight from a flop.
module pe_array_ctrl #(
   parameter int ROWS          = 4,
   parameter int COLS          = 4,
   parameter int ID_WIDTH      = 6,
   parameter int IN_DATA_WIDTH = 8,
   parameter int LEN_WIDTH     = 12,
   parameter int DRAIN_CYC     = 16,
   parameter int FLUSH_CYC     = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_cmd_vld,
   output logic                          o_cmd_rdy,
   input  logic [LEN_WIDTH-1:0]          i_cmd_len,
   input  logic                          s_wgt_vld,
   output logic                          s_wgt_rdy,
   input  logic [IN_DATA_WIDTH-1:0]      s_wgt_data,
   input  logic                          s_act_vld,
   output logic                          s_act_rdy,
   input  logic [ROWS*IN_DATA_WIDTH-1:0] s_act_data,
   output logic                          o_pe_rst,
   output logic                          o_load_vld,
   output logic [ID_WIDTH-1:0]           o_load_id,
   output logic [IN_DATA_WIDTH-1:0]      o_load_data,
   output logic                          o_pop_vld,
   output logic                          o_left_vld,
   output logic [ROWS*IN_DATA_WIDTH-1:0] o_left_data,
   output logic                          o_busy,
   output logic                          o_done
);

   localparam int NPE     = ROWS * COLS;
   localparam int BEAT_W  = (2 * NPE > 2) ? $clog2(2 * NPE) : 1;
   localparam int CNT_MAX = (DRAIN_CYC > FLUSH_CYC) ? DRAIN_CYC : FLUSH_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 2;
   localparam int AW      = ROWS * IN_DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, LOAD, DRAIN, COMP0, SWAP, COMP1, RESTORE, FLUSH
   } state_e;

   state_e                   state_q, state_d;
   logic [LEN_WIDTH-1:0]     len_q, len_d;
   logic [BEAT_W-1:0]        beat_q, beat_d;
   logic [ID_WIDTH-1:0]      id_q, id_d;
   logic [LEN_WIDTH-1:0]     vec_q, vec_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0]               init_q, init_d;
   logic                     cmd_rdy_q, cmd_rdy_d;
   logic                     wgt_rdy_q, wgt_rdy_d;
   logic                     act_rdy_q, act_rdy_d;
   logic                     pe_rst_q, pe_rst_d;
   logic                     load_vld_q, load_vld_d;
   logic [ID_WIDTH-1:0]      load_id_q, load_id_d;
   logic [IN_DATA_WIDTH-1:0] load_data_q, load_data_d;
   logic                     pop_vld_q, pop_vld_d;
   logic                     left_vld_q, left_vld_d;
   logic [AW-1:0]            left_data_q, left_data_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic accept, wgt_hs, act_hs;

   assign accept = i_cmd_vld && cmd_rdy_q;
   assign wgt_hs = s_wgt_vld && wgt_rdy_q;
   assign act_hs = s_act_vld && act_rdy_q;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      beat_d      = beat_q;
      id_d        = id_q;
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      init_d      = {init_q[0], 1'b1};
      pe_rst_d    = ~init_q[1];
      wgt_rdy_d   = 1'b0;
      act_rdy_d   = 1'b0;
      load_vld_d  = 1'b0;
      load_id_d   = load_id_q;
      load_data_d = load_data_q;
      pop_vld_d   = 1'b0;
      left_vld_d  = 1'b0;
      left_data_d = '0;
      done_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               len_d     = i_cmd_len;
               beat_d    = '0;
               id_d      = '0;
               vec_d     = '0;
               cnt_d     = '0;
               pe_rst_d  = 1'b1;
               wgt_rdy_d = 1'b1;
               state_d   = LOAD;
            end
         end
         // Both banks share one ID sequence; the beat counter tracks which pass we are in.
         LOAD: begin
            wgt_rdy_d = 1'b1;
            if (wgt_hs) begin
               load_vld_d  = 1'b1;
               load_id_d   = id_q;
               load_data_d = s_wgt_data;
               id_d        = (id_q == ID_WIDTH'(NPE - 1)) ? '0 : id_q + 1'b1;
               if (beat_q == BEAT_W'(2 * NPE - 1)) begin
                  beat_d    = '0;
                  wgt_rdy_d = 1'b0;
                  state_d   = DRAIN;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
               cnt_d = '0;
               if (len_q == '0) begin
                  state_d = FLUSH;
               end else begin
                  act_rdy_d = 1'b1;
                  state_d   = COMP0;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         COMP0, COMP1: begin
            act_rdy_d = 1'b1;
            if (act_hs) begin
               left_vld_d  = 1'b1;
               left_data_d = s_act_data;
               if (vec_q == len_q - 1'b1) begin
                  vec_d     = '0;
                  act_rdy_d = 1'b0;
                  state_d   = (state_q == COMP0) ? SWAP : RESTORE;
               end else begin
                  vec_d = vec_q + 1'b1;
               end
            end
         end
         // Two quiet cycles let the last vector enter the array before the bank toggles.
         SWAP, RESTORE: begin
            if (cnt_q == CNT_W'(1)) begin
               cnt_d     = '0;
               pop_vld_d = 1'b1;
               if (state_q == SWAP) begin
                  act_rdy_d = 1'b1;
                  state_d   = COMP1;
               end else begin
                  state_d = FLUSH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         FLUSH: begin
            if (cnt_q == CNT_W'(FLUSH_CYC - 1)) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      cmd_rdy_d = (state_q == IDLE) && !accept;
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= '0;
         beat_q      <= '0;
         id_q        <= '0;
         vec_q       <= '0;
         cnt_q       <= '0;
         init_q      <= '0;
         cmd_rdy_q   <= 1'b0;
         wgt_rdy_q   <= 1'b0;
         act_rdy_q   <= 1'b0;
         pe_rst_q    <= 1'b1;
         load_vld_q  <= 1'b0;
         load_id_q   <= '0;
         load_data_q <= '0;
         pop_vld_q   <= 1'b0;
         left_vld_q  <= 1'b0;
         left_data_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         beat_q      <= beat_d;
         id_q        <= id_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         init_q      <= init_d;
         cmd_rdy_q   <= cmd_rdy_d;
         wgt_rdy_q   <= wgt_rdy_d;
         act_rdy_q   <= act_rdy_d;
         pe_rst_q    <= pe_rst_d;
         load_vld_q  <= load_vld_d;
         load_id_q   <= load_id_d;
         load_data_q <= load_data_d;
         pop_vld_q   <= pop_vld_d;
         left_vld_q  <= left_vld_d;
         left_data_q <= left_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign o_cmd_rdy   = cmd_rdy_q;
   assign s_wgt_rdy   = wgt_rdy_q;
   assign s_act_rdy   = act_rdy_q;
   assign o_pe_rst    = pe_rst_q;
   assign o_load_vld  = load_vld_q;
   assign o_load_id   = load_id_q;
   assign o_load_data = load_data_q;
   assign o_pop_vld   = pop_vld_q;
   assign o_left_vld  = left_vld_q;
   assign o_left_data = left_data_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: randomized bench for pe_array_ctrl; an event log is
// compared against the expected command timeline built from the stream handshakes.
module tb_pe_array_ctrl;

   localparam int ROWS          = 2;
   localparam int COLS          = 2;
   localparam int ID_WIDTH      = 6;
   localparam int IN_DATA_WIDTH = 8;
   localparam int LEN_WIDTH     = 12;
   localparam int DRAIN_CYC     = 16;
   localparam int FLUSH_CYC     = 8;
   localparam int NPE           = ROWS * COLS;
   localparam int AW            = ROWS * IN_DATA_WIDTH;

   logic                     clk;
   logic                     rst_n;
   logic                     i_cmd_vld;
   logic                     o_cmd_rdy;
   logic [LEN_WIDTH-1:0]     i_cmd_len;
   logic                     s_wgt_vld;
   logic                     s_wgt_rdy;
   logic [IN_DATA_WIDTH-1:0] s_wgt_data;
   logic                     s_act_vld;
   logic                     s_act_rdy;
   logic [AW-1:0]            s_act_data;
   logic                     o_pe_rst;
   logic                     o_load_vld;
   logic [ID_WIDTH-1:0]      o_load_id;
   logic [IN_DATA_WIDTH-1:0] o_load_data;
   logic                     o_pop_vld;
   logic                     o_left_vld;
   logic [AW-1:0]            o_left_data;
   logic                     o_busy;
   logic                     o_done;

   pe_array_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .ID_WIDTH(ID_WIDTH), .IN_DATA_WIDTH(IN_DATA_WIDTH),
      .LEN_WIDTH(LEN_WIDTH), .DRAIN_CYC(DRAIN_CYC), .FLUSH_CYC(FLUSH_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy),
      .i_cmd_len(i_cmd_len), .s_wgt_vld(s_wgt_vld), .s_wgt_rdy(s_wgt_rdy),
      .s_wgt_data(s_wgt_data), .s_act_vld(s_act_vld), .s_act_rdy(s_act_rdy),
      .s_act_data(s_act_data), .o_pe_rst(o_pe_rst), .o_load_vld(o_load_vld),
      .o_load_id(o_load_id), .o_load_data(o_load_data), .o_pop_vld(o_pop_vld),
      .o_left_vld(o_left_vld), .o_left_data(o_left_data), .o_busy(o_busy),
      .o_done(o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int                       whs_q[$], ahs_q[$], acc_q[$];
   int                       load_cyc_q[$], load_id_q[$], load_data_q[$];
   int                       left_cyc_q[$];
   logic [AW-1:0]            left_data_q[$];
   int                       pop_q[$], done_q[$], pe_rst_q[$];
   int                       load_id_bad, left_idle_bad;
   bit                       act_rdy_log[int];
   bit                       cmd_rdy_log[int];
   logic [ID_WIDTH-1:0]      prev_id;
   logic [IN_DATA_WIDTH-1:0] wgt_arr[2*NPE];
   logic [AW-1:0]            act_arr[$];

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Handshakes are taken at the active edge and stamped with that edge's number.
   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) begin
         if (s_wgt_vld && s_wgt_rdy) whs_q.push_back(cyc);
         if (s_act_vld && s_act_rdy) ahs_q.push_back(cyc);
         if (i_cmd_vld && o_cmd_rdy) acc_q.push_back(cyc);
      end
   end

   // Outputs are sampled on the falling edge and stamped with the preceding active edge.
   initial forever begin
      @(negedge clk);
      if (o_load_vld) begin
         load_cyc_q.push_back(cyc);
         load_id_q.push_back(int'(o_load_id));
         load_data_q.push_back(int'(o_load_data));
      end else if (o_load_id != prev_id) begin
         load_id_bad++;
      end
      prev_id = o_load_id;
      if (o_left_vld) begin
         left_cyc_q.push_back(cyc);
         left_data_q.push_back(o_left_data);
      end else if (o_left_data != '0) begin
         left_idle_bad++;
      end
      if (o_pop_vld) pop_q.push_back(cyc);
      if (o_done)    done_q.push_back(cyc);
      if (o_pe_rst)  pe_rst_q.push_back(cyc);
      act_rdy_log[cyc] = s_act_rdy;
      cmd_rdy_log[cyc] = o_cmd_rdy;
   end

   task automatic clearLogs();
      whs_q.delete(); ahs_q.delete(); acc_q.delete();
      load_cyc_q.delete(); load_id_q.delete(); load_data_q.delete();
      left_cyc_q.delete(); left_data_q.delete();
      pop_q.delete(); done_q.delete(); pe_rst_q.delete();
      act_rdy_log.delete(); cmd_rdy_log.delete();
      load_id_bad   = 0;
      left_idle_bad = 0;
      prev_id       = o_load_id;
   endtask

   task automatic checkResetRelease();
      @(negedge clk);
      checkOutput("pe_rst_hold1", o_pe_rst, 1);
      checkOutput("idle_after_reset", {o_busy, o_cmd_rdy}, 2'b01);
      @(negedge clk);
      checkOutput("pe_rst_hold2", o_pe_rst, 1);
      @(negedge clk);
      checkOutput("pe_rst_release", o_pe_rst, 0);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_outs_zero"},
                  {o_cmd_rdy, s_wgt_rdy, s_act_rdy, o_load_vld, o_pop_vld, o_left_vld,
                   o_busy, o_done, o_load_id, o_load_data, o_left_data}, 0);
      checkOutput({tag, "_pe_rst"}, o_pe_rst, 1);
   endtask

   task automatic verifyCommand(input int len, input int amode);
      int ll, t0, t1, n;
      checkOutput("accepts", acc_q.size(), 1);
      checkOutput("pe_rst_pulses", pe_rst_q.size(), 1);
      if (pe_rst_q.size() > 0 && acc_q.size() > 0)
         checkOutput("pe_rst_cycle", pe_rst_q[0], acc_q[0]);
      checkOutput("wgt_hs_count", whs_q.size(), 2 * NPE);
      checkOutput("load_count", load_cyc_q.size(), 2 * NPE);
      n = (load_cyc_q.size() < whs_q.size()) ? load_cyc_q.size() : whs_q.size();
      for (int k = 0; k < n; k++) begin
         checkOutput("load_id", load_id_q[k], k % NPE);
         checkOutput("load_data", load_data_q[k], int'(wgt_arr[k]));
         checkOutput("load_latency", load_cyc_q[k], whs_q[k]);
      end
      checkOutput("load_id_bubble", load_id_bad, 0);
      checkOutput("left_idle_zero", left_idle_bad, 0);
      checkOutput("act_hs_count", ahs_q.size(), 2 * len);
      checkOutput("left_count", left_cyc_q.size(), 2 * len);
      n = (left_cyc_q.size() < ahs_q.size()) ? left_cyc_q.size() : ahs_q.size();
      for (int k = 0; k < n && k < act_arr.size(); k++) begin
         checkOutput("left_data", left_data_q[k], act_arr[k]);
         checkOutput("left_latency", left_cyc_q[k], ahs_q[k]);
      end
      checkOutput("pop_count", pop_q.size(), (len > 0) ? 2 : 0);
      checkOutput("done_count", done_q.size(), 1);
      if (load_cyc_q.size() != 2 * NPE || done_q.size() != 1) return;
      ll = load_cyc_q[2*NPE-1];
      if (len == 0) begin
         checkOutput("done_len0", done_q[0], ll + DRAIN_CYC + FLUSH_CYC);
      end else if (left_cyc_q.size() == 2 * len && pop_q.size() == 2) begin
         t0 = left_cyc_q[len-1];
         t1 = left_cyc_q[2*len-1];
         if (amode == 0) checkOutput("first_left", left_cyc_q[0], ll + DRAIN_CYC + 1);
         else            checkOutput("first_left_min", left_cyc_q[0] >= ll + DRAIN_CYC + 1, 1);
         checkOutput("pop0_cycle", pop_q[0], t0 + 2);
         checkOutput("swap_rdy", {act_rdy_log[t0], act_rdy_log[t0+1], act_rdy_log[t0+2]}, 3'b001);
         if (amode == 0) checkOutput("bank1_first", left_cyc_q[len], t0 + 3);
         else            checkOutput("bank1_first_min", left_cyc_q[len] >= t0 + 3, 1);
         checkOutput("pop1_cycle", pop_q[1], t1 + 2);
         checkOutput("restore_rdy", {act_rdy_log[t1], act_rdy_log[t1+1], act_rdy_log[t1+2]}, 3'b000);
         checkOutput("done_cycle", done_q[0], t1 + 2 + FLUSH_CYC);
      end
      checkOutput("cmd_rdy_at_done", cmd_rdy_log[done_q[0]], 0);
      checkOutput("cmd_rdy_after_done", cmd_rdy_log[done_q[0]+1], 1);
   endtask

   // wmode: 0 continuous, 1 toggling, 2 random; amode: 0 continuous, 1 random.
   task automatic applyStimulus(input int len, input int wmode, input int amode,
                                input bit busy_cmd, input int abort_at);
      bit seen_done;
      int extra, k;
      seen_done = 0;
      extra     = 0;
      clearLogs();
      for (int i = 0; i < 2 * NPE; i++) wgt_arr[i] = IN_DATA_WIDTH'($urandom);
      act_arr.delete();
      for (int i = 0; i < 2 * len; i++) act_arr.push_back(AW'($urandom));
      i_cmd_vld = 1'b1;
      i_cmd_len = LEN_WIDTH'(len);
      for (int c = 0; c < 12000; c++) begin
         @(negedge clk);
         if (abort_at >= 0 && left_cyc_q.size() >= abort_at) begin
            #2 rst_n = 1'b0;
            #1 checkResetOutputs("abort");
            i_cmd_vld = 1'b0; s_wgt_vld = 1'b0; s_act_vld = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            checkResetRelease();
            clearLogs();
            repeat (30) @(negedge clk);
            checkOutput("abort_no_events",
                        pop_q.size() + done_q.size() + left_cyc_q.size() + load_cyc_q.size(), 0);
            return;
         end
         if (o_done) seen_done = 1;
         if (seen_done) begin
            i_cmd_vld = 1'b0;
            extra++;
            if (extra > 5) break;
         end else if (acc_q.size() > 0) begin
            i_cmd_vld = busy_cmd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy_cmd) i_cmd_len = LEN_WIDTH'($urandom);
         end
         k = whs_q.size();
         case (wmode)
            0:       s_wgt_vld = 1'b1;
            1:       s_wgt_vld = c[0];
            default: s_wgt_vld = 1'($urandom_range(0, 1));
         endcase
         s_wgt_data = (k < 2 * NPE) ? wgt_arr[k] : IN_DATA_WIDTH'($urandom);
         k = ahs_q.size();
         s_act_vld  = (amode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         s_act_data = (k < act_arr.size()) ? act_arr[k] : AW'($urandom);
      end
      i_cmd_vld = 1'b0;
      s_wgt_vld = 1'b0;
      s_act_vld = 1'b0;
      if (!seen_done) checkOutput("done_timeout", 0, 1);
      verifyCommand(len, amode);
   endtask

   initial begin
      i_cmd_vld  = 1'b0;
      i_cmd_len  = '0;
      s_wgt_vld  = 1'b0;
      s_wgt_data = '0;
      s_act_vld  = 1'b0;
      s_act_data = '0;
      rst_n      = 1'b1;
      #1 rst_n   = 1'b0;
      #1 checkResetOutputs("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checkResetRelease();

      $display("[TB] len=3 continuous streams");
      applyStimulus(3, 0, 0, 0, -1);
      $display("[TB] len=3 toggling weight valid");
      applyStimulus(3, 1, 0, 0, -1);
      $display("[TB] len=0");
      applyStimulus(0, 0, 0, 0, -1);
      $display("[TB] command request while busy");
      applyStimulus(4, 0, 0, 1, -1);
      $display("[TB] reset during bank-1 compute");
      applyStimulus(5, 0, 0, 0, 7);
      $display("[TB] command after abort");
      applyStimulus(2, 0, 0, 0, -1);
      $display("[TB] randomized commands");
      for (int i = 0; i < 6; i++)
         applyStimulus($urandom_range(1, 6), $urandom_range(0, 2), $urandom_range(0, 1),
                       1'($urandom_range(0, 1)), -1);
      $display("[TB] maximum length");
      applyStimulus((1 << LEN_WIDTH) - 1, 0, 0, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_array_ctrl.md
Name: pe_array_ctrl

Overview:
- Sequencer for a ROWS x COLS grid of weight-stationary PEs. Each PE holds two weight banks, has an ID-addressed load chain, a shared pop toggle that selects the active bank, and left-edge activation inputs.
- Per command, the block:
  - loads both weight banks of every PE from a weight stream;
  - waits for the load chain to drain;
  - streams CMD_LEN activation vectors through bank 0;
  - swaps to bank 1 and streams CMD_LEN vectors again;
  - restores bank 0, flushes the pipeline and signals done.
- Sits between the DMA/buffer streams and the PE array.

Parameters:
ROWS, 4, PE rows (activation lanes)
COLS, 4, PE columns
ID_WIDTH, 6, load-chain ID width; ROWS*COLS must be <= 2**ID_WIDTH
IN_DATA_WIDTH, 8, weight/activation width
LEN_WIDTH, 12, width of vector-count field
DRAIN_CYC, 16, cycles waited after last load beat (>= load-chain hop count)
FLUSH_CYC, 8, cycles waited after final pop before done

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
i_cmd_vld  in  1  command request
o_cmd_rdy  out  1  high only in IDLE
i_cmd_len  in  LEN_WIDTH  vectors per bank
s_wgt_vld  in  1  weight stream valid
s_wgt_rdy  out  1  weight stream ready
s_wgt_data  in  IN_DATA_WIDTH  weight value
s_act_vld  in  1  activation vector valid
s_act_rdy  out  1  activation vector ready
s_act_data  in  ROWS*IN_DATA_WIDTH  one activation per row, row 0 in LSBs
o_pe_rst  out  1  active-high sync reset to PE array
o_load_vld  out  1  load-chain valid
o_load_id  out  ID_WIDTH  target PE ID
o_load_data  out  IN_DATA_WIDTH  weight
o_pop_vld  out  1  bank-toggle pulse to array
o_left_vld  out  1  activation vector valid at array left edge
o_left_data  out  ROWS*IN_DATA_WIDTH  activation vector
o_busy  out  1  state != IDLE
o_done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered. On reset: o_pe_rst=1; all other outputs 0; state=IDLE; counters 0.
- o_pe_rst:
  - stays high 2 cycles after rst_n deasserts;
  - pulses high for 1 cycle the cycle after each command accept, zeroing the PE load and pop indices.
- States: IDLE, LOAD, DRAIN, COMP0, SWAP, COMP1, RESTORE, FLUSH.
- IDLE: a command is accepted when i_cmd_vld && o_cmd_rdy. Latch i_cmd_len, then go to LOAD.
- LOAD:
  - s_wgt_rdy=1.
  - Each handshake produces o_load_vld=1 one cycle later, with o_load_data equal to the beat's data.
  - o_load_id sequence: 0..ROWS*COLS-1 for bank 0, then repeats 0..ROWS*COLS-1 for bank 1; 2*ROWS*COLS beats total.
  - Gaps in s_wgt_vld insert bubbles (o_load_vld=0; ID unchanged).
  - After the last beat go to DRAIN.
- DRAIN: wait exactly DRAIN_CYC cycles. If latched len==0, go to FLUSH (no pops, no activations); otherwise go to COMP0.
- COMP0/COMP1:
  - s_act_rdy=1 until len handshakes have completed in the current state.
  - Each handshake produces o_left_vld=1 and o_left_data=s_act_data one cycle later. When idle, o_left_vld=0 and o_left_data=0.
  - After the last handshake in COMP0 go to SWAP; after the last in COMP1 go to RESTORE.
- SWAP/RESTORE timing: let t be the cycle of the last o_left_vld of the preceding phase.
  - o_pop_vld=1 exactly at t+2, for 1 cycle.
  - s_act_rdy=0 until t+1, so the next o_left_vld is no earlier than t+3.
  - SWAP then goes to COMP1; RESTORE goes to FLUSH.
- The pop count is always 0 or 2 per command, so the PE bank select returns to 0.
- FLUSH: wait FLUSH_CYC cycles, then o_done=1 for 1 cycle and return to IDLE. o_cmd_rdy=1 from the following cycle.
- i_cmd_vld outside IDLE is ignored, with no effect on the running command.
- Reset mid-operation aborts immediately. No partial pops or done pulse are issued afterwards, and o_pe_rst resets the array.
- Counters: the beat counter wraps at 2*ROWS*COLS; the vector counter compares against the latched len, so len = 2**LEN_WIDTH-1 is supported.

Test Plan:
- ROWS=COLS=2, len=3, continuous streams -> 8 load beats with IDs 0,1,2,3,0,1,2,3; DRAIN of 16 cycles; 3 left beats; pop at last+2; 3 left beats; pop at last+2; done 8 cycles after second pop; exactly 2 pops.
- Weight stream valid toggling every other cycle -> o_load_vld alternates, IDs still in sequence, no beat dropped or duplicated.
- len=0 -> 8 load beats, no o_left_vld, no o_pop_vld, done DRAIN_CYC+FLUSH_CYC cycles after the last beat.
- s_act_vld held high across SWAP -> s_act_rdy low at t and t+1, first bank-1 o_left_vld at t+3, pop at t+2.
- rst_n asserted mid-COMP1 -> all outputs 0 asynchronously and o_pe_rst=1; after release o_pe_rst stays high 2 cycles; IDLE; next command runs correctly from ID 0.
- i_cmd_vld asserted while busy -> o_cmd_rdy=0, command ignored, one done pulse only.
